// File: rtl/snake_pkg.sv
// Shared turn encoding and default timing for the snake input path and game core.
// Pure types/constants; no latency, no flow control.
package snake_pkg;

    typedef enum logic [1:0] {
        TURN_NONE  = 2'd0,
        TURN_RIGHT = 2'd1,
        TURN_LEFT  = 2'd2
    } turn_t;

    localparam int                DEB_W               = 20;
    localparam logic [24:0]       STEP_CYCLES_DEF     = 25'd16777216;
    localparam logic [DEB_W-1:0]  DEBOUNCE_CYCLES_DEF = 20'd500000;

    // First press in a window wins; a tie between both buttons is dropped.
    function automatic turn_t next_turn(input turn_t cur, input logic right, input logic left);
        next_turn = cur;
        if (cur == TURN_NONE) begin
            if (right && !left) begin
                next_turn = TURN_RIGHT;
            end else if (left && !right) begin
                next_turn = TURN_LEFT;
            end
        end
    endfunction

endpackage

// File: rtl/snake_btn_debounce.sv
// Synchronises and debounces one active-low raw button; pulses press on a debounced fall.
// Latency: 2 sync + DEBOUNCE_CYCLES stable samples; no backpressure, free-running.
module snake_btn_debounce
    import snake_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEBOUNCE_CYCLES - DEB_W'(1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 != level) begin
                if (cnt == DEB_LAST) begin
                    level <= sync_q2;
                    cnt   <= '0;
                    // Only the released->pressed transition is an event.
                    press <= ~sync_q2;
                end else begin
                    cnt <= cnt + DEB_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/snake_input_ctrl.sv
// Button conditioning, game step tick and one-turn-per-step latch for the snake core.
// Press->pending 2+DEBOUNCE_CYCLES+1 cycles; turn_* valid the cycle after step_pulse; no backpressure.
module snake_input_ctrl
    import snake_pkg::*;
#(
    parameter int               CNT_W           = 25,
    parameter logic [CNT_W-1:0] STEP_CYCLES     = CNT_W'(STEP_CYCLES_DEF),
    parameter logic [DEB_W-1:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic bt0,
    input  logic bt1,
    input  logic enable,
    output logic step_pulse,
    output logic turn_right,
    output logic turn_left,
    output logic pending
);

    localparam logic [CNT_W-1:0] STEP_LAST = STEP_CYCLES - CNT_W'(1);

    logic             right_evt;
    logic             left_evt;
    logic [CNT_W-1:0] step_cnt;
    turn_t            turn_state;

    snake_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk   (clk),
        .rst   (rst),
        .btn   (bt0),
        .press (right_evt)
    );

    snake_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk   (clk),
        .rst   (rst),
        .btn   (bt1),
        .press (left_evt)
    );

    // Holding at 0 while disabled makes the first tick land a full step after enable rises.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            step_cnt <= '0;
        end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

    assign step_pulse = enable && (step_cnt == STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            turn_state <= TURN_NONE;
            turn_right <= 1'b0;
            turn_left  <= 1'b0;
        end else if (step_pulse) begin
            turn_right <= (turn_state == TURN_RIGHT);
            turn_left  <= (turn_state == TURN_LEFT);
            // An event coincident with the tick belongs to the window that is opening.
            turn_state <= next_turn(TURN_NONE, right_evt, left_evt);
        end else begin
            turn_state <= next_turn(turn_state, right_evt, left_evt);
        end
    end

    assign pending = (turn_state != TURN_NONE);

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with STEP_CYCLES=16, DEBOUNCE_CYCLES=4.
// Inputs driven and outputs sampled on the falling clock edge; cyc counts falling edges since reset release.
module tb_snake_input_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic bt0;
    logic bt1;
    logic enable;
    logic step_pulse;
    logic turn_right;
    logic turn_left;
    logic pending;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    snake_input_ctrl #(
        .CNT_W           (25),
        .STEP_CYCLES     (25'd16),
        .DEBOUNCE_CYCLES (20'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bt0        (bt0),
        .bt1        (bt1),
        .enable     (enable),
        .step_pulse (step_pulse),
        .turn_right (turn_right),
        .turn_left  (turn_left),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_turn_right"}, turn_right, 1'b0);
        chk({tag, "_turn_left"},  turn_left,  1'b0);
        chk({tag, "_pending"},    pending,    1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        bt0    = 1'b1;
        bt1    = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        // Reset state
        chk("rst_step_pulse", step_pulse, 1'b0);
        chk_idle("rst");

        // 1: free-running tick at 15, 31, 47
        for (int c = 1; c <= 47; c++) begin
            run_to(c);
            chk("tick_phase", step_pulse, (c % 16) == 15);
            chk_idle("tick_idle");
        end

        // 2a: 3-cycle glitch on bt0 is invisible
        run_to(48); bt0 = 1'b0;
        run_to(51); bt0 = 1'b1;
        for (int c = 52; c <= 59; c++) begin
            run_to(c);
            chk("glitch_pending", pending, 1'b0);
        end

        // 2b: real press, pending exactly 7 cycles after the fall
        run_to(60); bt0 = 1'b0;
        run_to(66); chk("press_pending_early", pending, 1'b0);
        run_to(67); chk("press_pending", pending, 1'b1);
        run_to(70); bt0 = 1'b1;
        run_to(79);
        chk("press_tick", step_pulse, 1'b1);
        chk("press_right_before", turn_right, 1'b0);
        chk("press_pending_tick", pending, 1'b1);
        for (int c = 80; c <= 95; c++) begin
            run_to(c);
            chk("press_right_held", turn_right, 1'b1);
            chk("press_left_held", turn_left, 1'b0);
        end
        chk("press_pending_cleared", pending, 1'b0);
        run_to(96); chk("press_right_drop", turn_right, 1'b0);

        // 3a: left first, then right in the same window -> left wins
        run_to(97);  bt1 = 1'b0;
        run_to(100); bt0 = 1'b0;
        run_to(104); chk("first_wins_pending", pending, 1'b1);
        run_to(110); bt0 = 1'b1; bt1 = 1'b1;
        run_to(111); chk("first_wins_tick", step_pulse, 1'b1);
        run_to(112);
        chk("first_wins_left", turn_left, 1'b1);
        chk("first_wins_right", turn_right, 1'b0);

        // 3b: both buttons fall together -> discarded
        run_to(118); bt0 = 1'b0; bt1 = 1'b0;
        run_to(125); chk("tie_pending", pending, 1'b0);
        run_to(128); chk_idle("tie_after_tick");
        run_to(130); bt0 = 1'b1; bt1 = 1'b1;

        // 4: event lands in the tick cycle -> belongs to the next window
        run_to(137); bt0 = 1'b0;
        run_to(143);
        chk("edge_tick", step_pulse, 1'b1);
        chk("edge_pending_tick", pending, 1'b0);
        run_to(144);
        chk_idle_excl_pending();
        chk("edge_pending_next", pending, 1'b1);
        run_to(147); bt0 = 1'b1;
        run_to(159); chk("edge_right_before", turn_right, 1'b0);
        run_to(160); chk("edge_right_after", turn_right, 1'b1);

        // 5: 100-cycle hold produces exactly one turn
        run_to(161); bt0 = 1'b0;
        run_to(168); chk("hold_pending", pending, 1'b1);
        run_to(176); chk("hold_right_once", turn_right, 1'b1);
        run_to(192); chk("hold_right_2", turn_right, 1'b0);
        run_to(200); chk("hold_pending_2", pending, 1'b0);
        run_to(208); chk("hold_right_3", turn_right, 1'b0);
        run_to(240); chk("hold_right_5", turn_right, 1'b0);
        run_to(250); chk("hold_pending_5", pending, 1'b0);
        run_to(261); bt0 = 1'b1;

        // 6a: synchronous reset discards a latched left turn and restarts the tick
        run_to(270); bt1 = 1'b0;
        run_to(275); bt1 = 1'b1;
        run_to(277); chk("rst_mid_pending_set", pending, 1'b1);
        run_to(278); rst = 1'b1;
        run_to(279); rst = 1'b0;
        chk("rst_mid_step", step_pulse, 1'b0);
        chk_idle("rst_mid");
        run_to(280); bt0 = 1'b0;
        run_to(290); bt0 = 1'b1;
        run_to(293); chk("rst_phase_before", step_pulse, 1'b0);
        run_to(294); chk("rst_phase_tick", step_pulse, 1'b1);
        run_to(295);
        chk("rst_discard_left", turn_left, 1'b0);
        chk("rst_new_right", turn_right, 1'b1);

        // 6b: enable low clears latch and outputs, freezes tick, held button stays quiet
        run_to(297); bt0 = 1'b0;
        run_to(304); chk("en_pending_set", pending, 1'b1);
        run_to(305); enable = 1'b0;
        chk("en_low_step_now", step_pulse, 1'b0);
        for (int c = 306; c <= 345; c++) begin
            run_to(c);
            chk("en_low_step", step_pulse, 1'b0);
            chk_idle("en_low");
        end
        run_to(346); enable = 1'b1;
        for (int c = 347; c <= 360; c++) begin
            run_to(c);
            chk("en_rise_step", step_pulse, 1'b0);
            chk("en_rise_pending", pending, 1'b0);
        end
        run_to(361);
        chk("en_rise_first_tick", step_pulse, 1'b1);
        bt0 = 1'b1;
        run_to(362); chk_idle("en_rise_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk_idle_excl_pending();
        chk("edge_turn_right", turn_right, 1'b0);
        chk("edge_turn_left",  turn_left,  1'b0);
    endtask

endmodule
